// File: rtl/int2fp_encoder.sv
// Signed 32-bit integer to FPU float encoder (1/11/20 format, bias 1023), four-cycle fixed latency.
// Optional macro INT2FP_ROUND_NEAREST_EN selects round-to-nearest-even; default build truncates.
module int2fp_encoder (
  input  logic        clock_100k,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic [2:0]  debug_state
);

  // Handshake: start/int_in are sampled on a rising edge only while idle (busy low);
  // done is a one-cycle pulse and data_out/status_out hold until the next done.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_UNPACK    = 3'd1,
    S_NORMALIZE = 3'd2,
    S_ROUND     = 3'd3,
    S_OUTPUT    = 3'd4
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [31:0] int_r;
  logic        sign_r;
  logic [31:0] mag_r;
  logic        zero_r;
  logic [10:0] exp_r;
  logic [19:0] frac_r;
  logic        guard_r;
  logic        sticky_r;
  logic        inexact_r;
  logic        done_r;
  logic [31:0] data_r;
  logic [3:0]  status_r;

  logic [4:0]  msb_idx;
  logic [31:0] norm;
  logic        round_inc;
  logic [20:0] frac_sum;

  always_ff @(posedge clock_100k) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (start) next_state = S_UNPACK;
      S_UNPACK:    next_state = S_NORMALIZE;
      S_NORMALIZE: next_state = S_ROUND;
      S_ROUND:     next_state = S_OUTPUT;
      S_OUTPUT:    next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Shifting the MSB up to bit 31 lines fraction, guard and sticky up at fixed positions.
  always_comb begin
    msb_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_r[i]) msb_idx = i[4:0];
    end
    norm = mag_r << (5'd31 - msb_idx);
  end

`ifdef INT2FP_ROUND_NEAREST_EN
  assign round_inc = guard_r & (sticky_r | frac_r[0]);
`else
  assign round_inc = 1'b0;
`endif

  assign frac_sum = {1'b0, frac_r} + {20'd0, round_inc};

  always_ff @(posedge clock_100k) begin
    if (reset) begin
      int_r     <= '0;
      sign_r    <= 1'b0;
      mag_r     <= '0;
      zero_r    <= 1'b0;
      exp_r     <= '0;
      frac_r    <= '0;
      guard_r   <= 1'b0;
      sticky_r  <= 1'b0;
      inexact_r <= 1'b0;
      done_r    <= 1'b0;
      data_r    <= '0;
      status_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) int_r <= int_in;
        end
        S_UNPACK: begin
          sign_r <= int_r[31];
          // 0x80000000 negates to itself, which is the correct 2^31 magnitude.
          mag_r  <= int_r[31] ? (~int_r + 32'd1) : int_r;
        end
        S_NORMALIZE: begin
          zero_r   <= (mag_r == 32'd0);
          exp_r    <= (mag_r == 32'd0) ? 11'd0 : (11'd1023 + {6'd0, msb_idx});
          frac_r   <= norm[30:11];
          guard_r  <= norm[10];
          sticky_r <= |norm[9:0];
        end
        S_ROUND: begin
          frac_r    <= frac_sum[19:0];
          exp_r     <= exp_r + {10'd0, frac_sum[20]};
          inexact_r <= guard_r | sticky_r;
        end
        S_OUTPUT: begin
          done_r   <= 1'b1;
          data_r   <= zero_r ? 32'd0 : {sign_r, exp_r, frac_r};
          status_r <= {~inexact_r, 2'b00, inexact_r};
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_r;
  assign data_out    = data_r;
  assign status_out  = status_r;
  assign debug_state = state;

endmodule

// File: tb/tb_int2fp_encoder.sv
// Directed bench for int2fp_encoder: driver pushes expected results, a negedge monitor pops and compares.
module tb_int2fp_encoder;

  logic        clock_100k = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] int_in = '0;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic [2:0]  debug_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [35:0] exp_q[$];
  int          cyc_q[$];

  int2fp_encoder dut (
    .clock_100k (clock_100k),
    .reset      (reset),
    .start      (start),
    .int_in     (int_in),
    .busy       (busy),
    .done       (done),
    .data_out   (data_out),
    .status_out (status_out),
    .debug_state(debug_state)
  );

  // clock / reset
  always #5 clock_100k = ~clock_100k;
  always @(posedge clock_100k) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock_100k) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
      end else begin
        logic [35:0] e;
        int          ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("data_out", data_out, e[31:0]);
        check("status_out", {28'd0, status_out}, {28'd0, e[35:32]});
        check("done_latency", cyc, ec);
        check("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  // driver: call on a negedge; start is sampled at the following posedge
  task automatic push_expected(input logic [31:0] d, input logic [3:0] s);
    exp_q.push_back({s, d});
    cyc_q.push_back(cyc + 5);
  endtask

  task automatic convert(input logic [31:0] v, input logic [31:0] d, input logic [3:0] s);
    @(negedge clock_100k);
    start  = 1'b1;
    int_in = v;
    push_expected(d, s);
    @(negedge clock_100k);
    start  = 1'b0;
    int_in = 32'hDEADBEEF;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clock_100k);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
    @(negedge clock_100k);
  endtask

  initial begin
    logic [31:0] max_exp;
    logic [31:0] tie3_exp;
`ifdef INT2FP_ROUND_NEAREST_EN
    max_exp  = 32'h41E00000;
    tie3_exp = 32'h41400002;
`else
    max_exp  = 32'h41DFFFFF;
    tie3_exp = 32'h41400001;
`endif

    // reset for two cycles
    reset = 1'b1;
    repeat (2) @(posedge clock_100k);
    @(negedge clock_100k);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_data", data_out, 32'd0);
    check("reset_status", {28'd0, status_out}, 32'd0);
    reset = 1'b0;

    // basic and boundary vectors
    convert(32'h00000001, 32'h3FF00000, 4'b1000); drain(20);
    convert(32'hFFFFFFFF, 32'hBFF00000, 4'b1000); drain(20);
    convert(32'h00000000, 32'h00000000, 4'b1000); drain(20);
    convert(32'h80000000, 32'hC1E00000, 4'b1000); drain(20);
    convert(32'h7FFFFFFF, max_exp,      4'b0001); drain(20);
    convert(32'h00200001, 32'h41400000, 4'b0001); drain(20);
    convert(32'h00200003, tie3_exp,     4'b0001); drain(20);
    convert(32'h00000005, 32'h40140000, 4'b1000); drain(20);

    // start held every cycle: accepted at k=0,5,10 (values 1, 6, 11)
    for (int k = 0; k < 15; k++) begin
      @(negedge clock_100k);
      start  = 1'b1;
      int_in = 32'(k + 1);
      if (k == 0)  push_expected(32'h3FF00000, 4'b1000);
      if (k == 5)  push_expected(32'h40180000, 4'b1000);
      if (k == 10) push_expected(32'h40260000, 4'b1000);
    end
    @(negedge clock_100k);
    start = 1'b0;
    drain(30);

    // reset during ROUND of a conversion of 5: no done, outputs cleared
    @(negedge clock_100k);
    start  = 1'b1;
    int_in = 32'd5;
    @(negedge clock_100k);
    start  = 1'b0;
    @(negedge clock_100k);
    @(negedge clock_100k);
    check("pre_reset_state_round", {29'd0, debug_state}, 32'd3);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clock_100k);
    reset = 1'b0;
    start = 1'b0;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_data", data_out, 32'd0);
    check("midreset_status", {28'd0, status_out}, 32'd0);
    repeat (8) @(negedge clock_100k);
    check("midreset_no_start", {31'd0, busy}, 32'd0);
    convert(32'h00000005, 32'h40140000, 4'b1000); drain(20);

    repeat (3) @(negedge clock_100k);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
